cmd_bus_arbiter: RTL and testbench

CMD_BUS_ARBITER -- requirements
Module: cmd_bus_arbiter

---
 rtl/cmd_bus_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 12 +
 rtl/cmd_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_cmd_bus_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_bus_pkg.sv
// Shared definitions for the command-bus arbiter: FSM encoding, command-word
// field positions and readback constants.
package cmd_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      GAP
   } arbState_t;

   localparam int SLV_MSB = 31;
   localparam int SLV_LSB = 29;
   localparam int OP_BIT  = 28;

   localparam logic OP_GET = 1'b0;
   localparam logic OP_SET = 1'b1;

   // Slaves answer an unknown register with this word.
   localparam logic [31:0] ERR_RDATA = 32'hA55AAA55;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, otherwise the requester
// that was not granted last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   assign grant[0] = req[0] & (~req[1] | last);
   assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Two-requester command-bus arbiter: serialises commands onto a shared
// trigger/command bus and returns slave readback to the granted requester.
module cmd_bus_arbiter
   import cmd_bus_pkg::*;
#(
   parameter int RSP_WAIT    = 6,
   parameter int TRIG_CYCLES = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic         clk,
   input  logic         rest,
   input  logic         req0,
   input  logic         req1,
   input  logic [31:0]  cmd0,
   input  logic [31:0]  cmd1,
   output logic         ack0,
   output logic         ack1,
   output logic [31:0]  rdata0,
   output logic [31:0]  rdata1,
   output logic [31:0]  bus_cmd,
   output logic         bus_trig,
   input  logic [255:0] slv_rdata
);

   // Assumes TRIG_CYCLES >= 1, GAP_CYCLES >= 1 and RSP_WAIT > TRIG_CYCLES.
   localparam int WAIT_CYCLES = RSP_WAIT - TRIG_CYCLES;
   localparam int MAX_A       = (TRIG_CYCLES > WAIT_CYCLES) ? TRIG_CYCLES : WAIT_CYCLES;
   localparam int CNT_MAX     = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   arbState_t        stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   logic             grantReg, grantNext;
   logic             lastReg, lastNext;
   logic [31:0]      busCmdReg, busCmdNext;
   logic [31:0]      rdata0Reg, rdata0Next;
   logic [31:0]      rdata1Reg, rdata1Next;
   logic [1:0]       arbGrant;
   logic [31:0]      captureWord;
   logic [31:0]      slvWord [8];

   for (genvar gi = 0; gi < 8; gi++) begin : gSlvWord
      assign slvWord[gi] = slv_rdata[32*gi +: 32];
   end

   rr_arb2 uArb (
      .req   ({req1, req0}),
      .last  (lastReg),
      .grant (arbGrant)
   );

   assign captureWord = (busCmdReg[OP_BIT] == OP_SET) ? 32'h0
                                                     : slvWord[busCmdReg[SLV_MSB:SLV_LSB]];

   always_ff @(posedge clk) begin
      if (rest) begin
         stateReg  <= IDLE;
         cntReg    <= '0;
         grantReg  <= 1'b0;
         lastReg   <= 1'b1;
         busCmdReg <= '0;
         rdata0Reg <= '0;
         rdata1Reg <= '0;
      end else begin
         stateReg  <= stateNext;
         cntReg    <= cntNext;
         grantReg  <= grantNext;
         lastReg   <= lastNext;
         busCmdReg <= busCmdNext;
         rdata0Reg <= rdata0Next;
         rdata1Reg <= rdata1Next;
      end
   end

   always_comb begin
      stateNext  = stateReg;
      cntNext    = cntReg;
      grantNext  = grantReg;
      lastNext   = lastReg;
      busCmdNext = busCmdReg;
      rdata0Next = rdata0Reg;
      rdata1Next = rdata1Reg;
      case (stateReg)
         IDLE: begin
            if (|arbGrant) begin
               stateNext  = ISSUE;
               cntNext    = '0;
               grantNext  = arbGrant[1];
               busCmdNext = arbGrant[1] ? cmd1 : cmd0;
            end
         end
         ISSUE: begin
            if (cntReg == TRIG_LAST) begin
               stateNext = WAIT;
               cntNext   = '0;
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end
         WAIT: begin
            // Readback is sampled on the edge into DONE so it is valid with the ack.
            if (cntReg == WAIT_LAST) begin
               stateNext = DONE;
               cntNext   = '0;
               if (grantReg) rdata1Next = captureWord;
               else          rdata0Next = captureWord;
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end
         DONE: begin
            lastNext  = grantReg;
            stateNext = GAP;
         end
         GAP: begin
            if (cntReg == GAP_LAST) begin
               stateNext = IDLE;
               cntNext   = '0;
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus_trig = (stateReg == ISSUE);
   assign ack0     = (stateReg == DONE) && !grantReg;
   assign ack1     = (stateReg == DONE) && grantReg;
   assign bus_cmd  = busCmdReg;
   assign rdata0   = rdata0Reg;
   assign rdata1   = rdata1Reg;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Bench for cmd_bus_arbiter: vector table of single commands, scoreboard of
// expected acks, and hand-written round-robin / drop / abort sequences.
module tb_cmd_bus_arbiter;

   localparam int RSP_WAIT    = 6;
   localparam int TRIG_CYCLES = 2;
   localparam int GAP_CYCLES  = 2;

   logic         clk;
   logic         rest;
   logic         req0, req1;
   logic [31:0]  cmd0, cmd1;
   logic         ack0, ack1;
   logic [31:0]  rdata0, rdata1;
   logic [31:0]  bus_cmd;
   logic         bus_trig;
   logic [255:0] slv_rdata;

   typedef struct {
      bit          who;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          who;
      logic [31:0] cmd;
      logic [31:0] expRdata;
   } vec_t;

   exp_t expQ[$];
   exp_t monE;
   vec_t vecs[8];

   int checks      = 0;
   int passes      = 0;
   int expEdges    = 0;
   int risingCount = 0;
   int lowRun      = 0;
   bit seenEdge    = 1'b0;
   bit prevTrig    = 1'b0;

   cmd_bus_arbiter #(
      .RSP_WAIT    (RSP_WAIT),
      .TRIG_CYCLES (TRIG_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) dut (
      .clk       (clk),
      .rest      (rest),
      .req0      (req0),
      .req1      (req1),
      .cmd0      (cmd0),
      .cmd1      (cmd1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .bus_cmd   (bus_cmd),
      .bus_trig  (bus_trig),
      .slv_rdata (slv_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expV);
      checks++;
      if (act === expV) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, expV);
   endtask

   // Scoreboard: every ack pops the oldest expected {requester, readback}.
   always @(negedge clk) begin
      if (!rest && (ack0 || ack1)) begin
         if (expQ.size() == 0) begin
            check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
         end else begin
            monE = expQ.pop_front();
            check("ack_requester", {30'd0, ack1, ack0}, monE.who ? 32'd2 : 32'd1);
            check("ack_rdata", ack1 ? rdata1 : rdata0, monE.rdata);
         end
      end
   end

   always @(negedge clk) begin
      if (rest) begin
         seenEdge = 1'b0;
         prevTrig = 1'b0;
         lowRun   = 0;
      end else begin
         if (bus_trig && !prevTrig) begin
            risingCount++;
            if (seenEdge) check("trig_gap", 32'(lowRun >= GAP_CYCLES), 32'd1);
            seenEdge = 1'b1;
            lowRun   = 0;
         end
         if (!bus_trig) lowRun++;
         prevTrig = bus_trig;
      end
   end

   task automatic checkReset();
      check("rst_bus_trig", 32'(bus_trig), 32'd0);
      check("rst_bus_cmd", bus_cmd, 32'd0);
      check("rst_ack0", 32'(ack0), 32'd0);
      check("rst_ack1", 32'(ack1), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
   endtask

   task automatic doReq(input bit who, input logic [31:0] cmd, input logic [31:0] expData);
      logic [31:0] otherBefore;
      int trigHigh, firstTrig, ackCyc, cmdOk;
      otherBefore = who ? rdata0 : rdata1;
      expQ.push_back('{who, expData});
      expEdges++;
      if (who) begin cmd1 = cmd; req1 = 1'b1; end
      else     begin cmd0 = cmd; req0 = 1'b1; end
      trigHigh = 0; firstTrig = -1; ackCyc = -1; cmdOk = 1;
      for (int c = 0; c < 60 && ackCyc < 0; c++) begin
         @(negedge clk);
         if (bus_trig) begin
            trigHigh++;
            if (firstTrig < 0) firstTrig = c;
         end
         if (firstTrig >= 0 && bus_cmd !== cmd) cmdOk = 0;
         if (who ? ack1 : ack0) ackCyc = c;
      end
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
      check("ack_seen", 32'(ackCyc >= 0), 32'd1);
      check("trig_cycles", trigHigh, TRIG_CYCLES);
      check("capture_latency", ackCyc - firstTrig, RSP_WAIT);
      check("other_rdata_hold", who ? rdata0 : rdata1, otherBefore);
      for (int g = 0; g < GAP_CYCLES; g++) begin
         @(negedge clk);
         if (bus_cmd !== cmd || bus_trig) cmdOk = 0;
      end
      check("bus_cmd_stable", cmdOk, 1);
      check("rdata_hold", who ? rdata1 : rdata0, expData);
      $display("txn req%0d cmd=%h rdata=%h", who, cmd, who ? rdata1 : rdata0);
      @(negedge clk);
   endtask

   initial begin
      int nAck, nAck0, got;

      vecs[0] = '{1'b0, 32'h6100_0000, 32'h0000_0015};
      vecs[1] = '{1'b1, 32'h7100_0009, 32'h0000_0000};
      vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0012};
      vecs[3] = '{1'b1, 32'hE000_00AB, 32'h0000_0019};
      vecs[4] = '{1'b0, 32'hF5FF_FFFF, 32'h0000_0000};
      vecs[5] = '{1'b1, 32'h4A00_0001, 32'h0000_0014};
      vecs[6] = '{1'b0, 32'h2C00_0000, 32'h0000_0013};
      vecs[7] = '{1'b1, 32'h9000_0000, 32'h0000_0000};

      slv_rdata = {32'h19, 32'h18, 32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12};
      rest = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
      repeat (3) @(negedge clk);
      checkReset();
      rest = 1'b0;

      // Simultaneous requests after reset, held: grants go 0,1,0,1.
      cmd0 = 32'h2000_0000; cmd1 = 32'h8000_0000;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) expQ.push_back('{k[0], k[0] ? 32'h16 : 32'h13});
      expEdges += 4;
      nAck = 0;
      for (int c = 0; c < 120 && nAck < 4; c++) begin
         @(negedge clk);
         if (ack0 || ack1) nAck++;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("rr_ack_count", nAck, 4);
      $display("txn rr pair x2 acks=%0d", nAck);
      repeat (GAP_CYCLES + 1) @(negedge clk);

      for (int i = 0; i < 8; i++) doReq(vecs[i].who, vecs[i].cmd, vecs[i].expRdata);

      // req0 withdrawn right after req1 wins the grant.
      doReq(1'b0, 32'h0000_0000, 32'h12);
      cmd0 = 32'hE000_0000; cmd1 = 32'h4A00_0001;
      req0 = 1'b1; req1 = 1'b1;
      expQ.push_back('{1'b1, 32'h14});
      expEdges++;
      @(negedge clk);
      req0 = 1'b0;
      check("rr_grant_bus_cmd", bus_cmd, 32'h4A00_0001);
      nAck0 = 0; got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         if (ack0) nAck0++;
         if (ack1) got = 1;
      end
      req1 = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (ack0) nAck0++;
      end
      check("req1_ack_seen", got, 1);
      check("dropped_req_no_ack", nAck0, 0);
      $display("txn req1 cmd=%h rdata=%h (req0 dropped)", cmd1, rdata1);

      // Reset pulsed during WAIT aborts the command.
      cmd0 = 32'h6100_0000; req0 = 1'b1;
      expEdges++;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (bus_trig) got = 1;
      end
      check("abort_trig_seen", got, 1);
      repeat (3) @(negedge clk);
      rest = 1'b1; req0 = 1'b0;
      @(negedge clk);
      checkReset();
      rest = 1'b0;
      nAck = 0;
      repeat (15) begin
         @(negedge clk);
         if (ack0 || ack1 || bus_trig) nAck++;
      end
      check("abort_quiet", nAck, 0);
      $display("txn req0 cmd=%h aborted by reset", cmd0);
      doReq(1'b1, 32'hE000_00AB, 32'h19);

      check("trig_edges", risingCount, expEdges);
      check("queue_drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
